seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
- Reverse direction of the team's hex-to-seven-segment encoder.
- Samples a time-multiplexed seven-segment bus (segment pattern plus one-hot digit strobe), filters glitches and decodes each stable pattern back to a 4-bit hex nibble.
- Assembles a full multi-digit frame and hands it out over a valid/ready handshake.
- Used as an on-chip display checker and for loopback self-test of display drivers.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; width of digit_sel.
- STABLE_CYCLES, 4: consecutive identical samples required before capture; legal range 1..255.

Ports:
- clk  input  1  single system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- seg_in  input  7  segment pattern, bit order GFEDCBA, 1 = segment lit
- digit_sel  input  NUM_DIGITS  one-hot digit strobe; bit i = digit i driven; all-zero = bus idle
- frame_value  output  4*NUM_DIGITS  decoded nibbles; digit i at bits [4i+3:4i]
- frame_blank  output  NUM_DIGITS  bit i set = digit i was blank (pattern 0x00)
- frame_valid  output  1  frame_value/frame_blank hold a complete, unconsumed frame
- frame_ready  input  1  consumer accepts frame when high with frame_valid
- err_pulse  output  1  one-cycle pulse: illegal pattern captured or multi-hot digit_sel
- ovf_pulse  output  1  one-cycle pulse: completed frame dropped because the output was occupied

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, run counter 0, seen mask 0, staging cleared.
- Decode table (GFEDCBA hex -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9
  - 77->A, 7C->b, 58->c, 5E->d, 79->E, 71->F
  - 00 -> nibble 0 with blank bit set.
  - Any other pattern is illegal.
- Each cycle, the current (digit_sel, seg_in) is compared with the previous cycle's registered sample.
- FSM states IDLE, SETTLE, CAPTURED:
  - IDLE: digit_sel not one-hot. All-zero is silent. Multi-hot gives err_pulse once on entry and again for each change of the multi-hot value. Counter held at 0. Enter SETTLE on the first one-hot sample, with counter = 1.
  - SETTLE: if the sample equals the previous sample, the counter increments. Any change restarts the count at 1 (stay in SETTLE) or goes to IDLE if digit_sel is not one-hot.
  - SETTLE capture: on the edge where the counter would reach STABLE_CYCLES, capture digit i into staging and set seen[i], then go to CAPTURED. With STABLE_CYCLES=1, capture occurs on the first sample.
  - CAPTURED: no further capture. Any change of sample goes to SETTLE (count 1) or to IDLE.
- Latency: with a sample first presented at edge t and held, capture occurs at edge t+STABLE_CYCLES-1.
- Illegal pattern at capture: err_pulse, no staging write, seen[i] unchanged, go to CAPTURED.
- Recapture of an already-seen digit overwrites its staging nibble and blank bit.
- Frame completion: when a capture makes seen all-ones, on the same edge:
  - If frame_valid==0, or frame_valid&&frame_ready in that cycle: load frame_value/frame_blank from staging (including the just-captured digit), set frame_valid=1, clear seen.
  - Otherwise: ovf_pulse, clear seen, old frame retained unchanged.
- Handshake:
  - frame_valid falls on the edge after frame_valid&&frame_ready, unless a new frame is loaded on that same edge (valid stays 1).
  - frame_value is stable while frame_valid=1 and not consumed.
- Counter saturates at STABLE_CYCLES; width clog2(STABLE_CYCLES+1).
- Mid-operation reset clears everything immediately. A partial frame is lost and no pulses are emitted.

Decomposition:
- Package seven_seg_pkg:
  - 7-bit segment constants SEG_0..SEG_F and SEG_BLANK (GFEDCBA).
  - FSM state enum {IDLE, SETTLE, CAPTURED}.
  - Shared with the existing encoder.
- Sub-module seven_seg_pattern_decode: purely combinational, seg[6:0] -> hex[3:0], blank, legal. Reusable by other checkers.

Test Plan:
- Scan with STABLE_CYCLES=4: sel=0001 seg=06, sel=0010 seg=5B, sel=0100 seg=4F, sel=1000 seg=66, each held 4 cycles, frame_ready=1 -> frame_valid pulses high one cycle at 4th cycle of digit 3, frame_value=16'h4321, frame_blank=0000, no err/ovf.
- Glitch filter: sel=0001, seg alternates 06/07 every 2 cycles for 10 cycles, then 3F held 4 cycles -> digit 0 captured as 0 only, no err_pulse.
- Illegal pattern: sel=0010, seg=7'h01 held 6 cycles -> exactly one err_pulse at 4th cycle; seen[1] stays 0. Multi-hot sel=0011 -> one err_pulse.
- Backpressure: frame_ready=0, complete frame 0xABCD then frame 0x1234 -> frame_value stays 16'hABCD, one ovf_pulse at second completion. Then frame_ready=1 for 1 cycle -> frame_valid falls next cycle.
- Blank and simultaneous accept: digit 2 pattern 00, frame_ready asserted on the exact cycle the next frame completes -> frame_valid stays 1, new value loaded, frame_blank=0100, no ovf.
- Reset mid-frame: reset_n low after 2 digits captured -> outputs 0 immediately. After release, next 4 digits form a clean frame equal to only post-reset data.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions (GFEDCBA bit order, 1 = lit) used by the
// display encoder and the scan decoder.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h58;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } scan_state_t;

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; flags blank and
// patterns that are not part of the glyph set.
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       blank,
    output logic       legal
);

    always_comb begin
        hex   = 4'h0;
        blank = 1'b0;
        legal = 1'b1;
        case (seg)
            SEG_0:     hex = 4'h0;
            SEG_1:     hex = 4'h1;
            SEG_2:     hex = 4'h2;
            SEG_3:     hex = 4'h3;
            SEG_4:     hex = 4'h4;
            SEG_5:     hex = 4'h5;
            SEG_6:     hex = 4'h6;
            SEG_7:     hex = 4'h7;
            SEG_8:     hex = 4'h8;
            SEG_9:     hex = 4'h9;
            SEG_A:     hex = 4'hA;
            SEG_B:     hex = 4'hB;
            SEG_C:     hex = 4'hC;
            SEG_D:     hex = 4'hD;
            SEG_E:     hex = 4'hE;
            SEG_F:     hex = 4'hF;
            SEG_BLANK: blank = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Samples a multiplexed seven-segment bus, debounces each digit, decodes it and
// assembles complete frames handed out over a valid/ready handshake.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] frame_value,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    err_pulse,
    output logic                    ovf_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    scan_state_t               state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [NUM_DIGITS-1:0]     prev_sel_q, prev_sel_d;
    logic [6:0]                prev_seg_q, prev_seg_d;
    logic [4*NUM_DIGITS-1:0]   staging_value_q, staging_value_d;
    logic [NUM_DIGITS-1:0]     staging_blank_q, staging_blank_d;
    logic [NUM_DIGITS-1:0]     seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0]   frame_value_q, frame_value_d;
    logic [NUM_DIGITS-1:0]     frame_blank_q, frame_blank_d;
    logic                      frame_valid_q, frame_valid_d;
    logic                      err_q, err_d;
    logic                      ovf_q, ovf_d;

    logic       sel_onehot;
    logic       sel_multi;
    logic       sample_same;
    logic       capture;
    logic [3:0] pat_hex;
    logic       pat_blank;
    logic       pat_legal;

    seven_seg_pattern_decode u_decode (
        .seg   (seg_in),
        .hex   (pat_hex),
        .blank (pat_blank),
        .legal (pat_legal)
    );

    assign sel_onehot  = (digit_sel != '0) &&
                         ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);
    assign sel_multi   = (digit_sel != '0) && !sel_onehot;
    assign sample_same = (digit_sel == prev_sel_q) && (seg_in == prev_seg_q);

    // Capture fires on the edge where the run of identical samples reaches
    // STABLE_CYCLES; CAPTURED then blocks re-capture until the sample changes.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_onehot) begin
                    state_d = SETTLE;
                    count_d = CNT_ONE;
                end else begin
                    count_d = '0;
                end
            end
            SETTLE: begin
                if (!sel_onehot) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (sample_same) begin
                    count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
                end else begin
                    count_d = CNT_ONE;
                end
            end
            CAPTURED: begin
                if (!sel_onehot) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!sample_same) begin
                    state_d = SETTLE;
                    count_d = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        if (state_d == SETTLE && count_d == CNT_MAX) begin
            capture = 1'b1;
            state_d = CAPTURED;
        end
    end

    // Multi-hot strobes only report when the strobe value itself is new, so a
    // stuck multi-hot bus does not flood err_pulse.
    always_comb begin
        prev_sel_d      = digit_sel;
        prev_seg_d      = seg_in;
        staging_value_d = staging_value_q;
        staging_blank_d = staging_blank_q;
        seen_d          = seen_q;
        frame_value_d   = frame_value_q;
        frame_blank_d   = frame_blank_q;
        frame_valid_d   = frame_valid_q;
        ovf_d           = 1'b0;
        err_d           = sel_multi && ((state_q != IDLE) || (digit_sel != prev_sel_q));

        if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end

        if (capture) begin
            if (!pat_legal) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (digit_sel[i]) begin
                        staging_value_d[4*i +: 4] = pat_hex;
                        staging_blank_d[i]        = pat_blank;
                    end
                end
                seen_d = seen_q | digit_sel;
                if (&seen_d) begin
                    seen_d = '0;
                    if (!frame_valid_q || frame_ready) begin
                        frame_value_d = staging_value_d;
                        frame_blank_d = staging_blank_d;
                        frame_valid_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            count_q         <= '0;
            prev_sel_q      <= '0;
            prev_seg_q      <= '0;
            staging_value_q <= '0;
            staging_blank_q <= '0;
            seen_q          <= '0;
            frame_value_q   <= '0;
            frame_blank_q   <= '0;
            frame_valid_q   <= 1'b0;
            err_q           <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            prev_sel_q      <= prev_sel_d;
            prev_seg_q      <= prev_seg_d;
            staging_value_q <= staging_value_d;
            staging_blank_q <= staging_blank_d;
            seen_q          <= seen_d;
            frame_value_q   <= frame_value_d;
            frame_blank_q   <= frame_blank_d;
            frame_valid_q   <= frame_valid_d;
            err_q           <= err_d;
            ovf_q           <= ovf_d;
        end
    end

    assign frame_value = frame_value_q;
    assign frame_blank = frame_blank_q;
    assign frame_valid = frame_valid_q;
    assign err_pulse   = err_q;
    assign ovf_pulse   = ovf_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench for seven_seg_scan_decoder: a run-length reference model
// predicts frames and pulses, a negedge monitor compares what the DUT presents.
module tb_seven_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
    } frame_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [6:0]    seg_in = '0;
    logic [ND-1:0] digit_sel = '0;
    logic          frame_ready = 1'b0;
    logic [15:0]   frame_value;
    logic [ND-1:0] frame_blank;
    logic          frame_valid;
    logic          err_pulse;
    logic          ovf_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    frame_t exp_frames[$];
    int     exp_err[$];
    int     exp_ovf[$];

    logic [3:0] m_prev_sel;
    logic [6:0] m_prev_seg;
    int         m_run;
    logic [3:0] m_nib [4];
    logic [3:0] m_blank;
    logic [3:0] m_seen;
    logic       m_valid;

    seven_seg_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .digit_sel   (digit_sel),
        .frame_value (frame_value),
        .frame_blank (frame_blank),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .err_pulse   (err_pulse),
        .ovf_pulse   (ovf_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void decode_ref(input logic [6:0] s, output logic [3:0] h,
                                       output logic b, output logic ok);
        h  = 4'h0;
        b  = 1'b0;
        ok = 1'b0;
        if (s == 7'h00) begin
            b  = 1'b1;
            ok = 1'b1;
        end
        for (int v = 0; v < 16; v++) begin
            if (SEG_TABLE[v] == s) begin
                h  = 4'(v);
                ok = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        m_prev_sel = '0;
        m_prev_seg = '0;
        m_run      = 0;
        m_blank    = '0;
        m_seen     = '0;
        m_valid    = 1'b0;
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        exp_frames.delete();
        exp_err.delete();
        exp_ovf.delete();
    endtask

    // Predicts the effect of the coming clock edge; pulses become visible one
    // cycle later, so they are tagged with cyc+1.
    task automatic model_edge(input logic [3:0] sel, input logic [6:0] seg, input logic rdy);
        int         ones;
        logic [3:0] h;
        logic       b;
        logic       ok;
        logic       load;
        frame_t     f;
        ones = $countones(sel);
        load = 1'b0;
        if (ones > 1 && sel != m_prev_sel) exp_err.push_back(cyc + 1);
        if (sel == m_prev_sel && seg == m_prev_seg) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev_sel = sel;
        m_prev_seg = seg;
        if (ones == 1 && m_run == SC) begin
            decode_ref(seg, h, b, ok);
            if (!ok) begin
                exp_err.push_back(cyc + 1);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        m_nib[i]   = h;
                        m_blank[i] = b;
                    end
                end
                m_seen = m_seen | sel;
                if (m_seen == 4'hF) begin
                    m_seen = '0;
                    if (!m_valid || rdy) begin
                        f.value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                        f.blank = m_blank;
                        exp_frames.push_back(f);
                        load = 1'b1;
                    end else begin
                        exp_ovf.push_back(cyc + 1);
                    end
                end
            end
        end
        if (m_valid && rdy) m_valid = 1'b0;
        if (load) m_valid = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [3:0] sel, input logic [6:0] seg,
                                  input int n, input logic rdy);
        for (int k = 0; k < n; k++) begin
            digit_sel   = sel;
            seg_in      = seg;
            frame_ready = rdy;
            model_edge(sel, seg, rdy);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic scan_frame(input logic [15:0] val, input logic [3:0] blank,
                              input int hold, input logic rdy);
        logic [6:0] s;
        for (int d = 0; d < 4; d++) begin
            s = blank[d] ? 7'h00 : SEG_TABLE[val[4*d +: 4]];
            apply_stimulus(4'(1) << d, s, hold, rdy);
        end
    endtask

    always @(negedge clk) begin : monitor
        frame_t f;
        if (frame_valid && frame_ready) begin
            if (exp_frames.size() == 0) begin
                check_output("unexpected_frame_accept", {16'h0, frame_value}, 32'hFFFF_FFFF);
            end else begin
                f = exp_frames.pop_front();
                check_output("frame_value", {16'h0, frame_value}, {16'h0, f.value});
                check_output("frame_blank", {28'h0, frame_blank}, {28'h0, f.blank});
            end
        end
        if (exp_err.size() > 0 && exp_err[0] == cyc) begin
            check_output("err_pulse", {31'h0, err_pulse}, 32'd1);
            void'(exp_err.pop_front());
        end else if (err_pulse) begin
            check_output("err_pulse_unexpected", {31'h0, err_pulse}, 32'd0);
        end
        if (exp_ovf.size() > 0 && exp_ovf[0] == cyc) begin
            check_output("ovf_pulse", {31'h0, ovf_pulse}, 32'd1);
            void'(exp_ovf.pop_front());
        end else if (ovf_pulse) begin
            check_output("ovf_pulse_unexpected", {31'h0, ovf_pulse}, 32'd0);
        end
    end

    initial begin
        logic [3:0] rsel;
        logic [6:0] rseg;
        int         hold;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_output("reset_frame_value", {16'h0, frame_value}, 32'h0);
        check_output("reset_frame_blank", {28'h0, frame_blank}, 32'h0);
        check_output("reset_frame_valid", {31'h0, frame_valid}, 32'h0);
        check_output("reset_err_pulse", {31'h0, err_pulse}, 32'h0);
        check_output("reset_ovf_pulse", {31'h0, ovf_pulse}, 32'h0);
        reset_n = 1'b1;

        // Basic scan, consumer always ready
        scan_frame(16'h4321, 4'b0000, 4, 1'b1);
        check_output("scan_valid", {31'h0, frame_valid}, 32'd1);
        check_output("scan_value", {16'h0, frame_value}, 32'h4321);

        // Glitch filter on digit 0
        for (int k = 0; k < 5; k++) apply_stimulus(4'b0001, (k % 2 == 0) ? 7'h06 : 7'h07, 2, 1'b1);
        apply_stimulus(4'b0001, 7'h3F, 4, 1'b1);

        // Illegal pattern and multi-hot strobe
        apply_stimulus(4'b0010, 7'h01, 6, 1'b1);
        apply_stimulus(4'b0011, 7'h06, 3, 1'b1);
        apply_stimulus(4'b0000, 7'h00, 2, 1'b1);

        // Backpressure: second frame overflows, first frame retained
        scan_frame(16'hABCD, 4'b0000, 4, 1'b0);
        scan_frame(16'h1234, 4'b0000, 4, 1'b0);
        check_output("bp_value_held", {16'h0, frame_value}, 32'hABCD);
        apply_stimulus(4'b0000, 7'h00, 1, 1'b1);
        apply_stimulus(4'b0000, 7'h00, 1, 1'b0);
        check_output("bp_valid_fell", {31'h0, frame_valid}, 32'd0);

        // Blank digit and accept on the completion edge
        scan_frame(16'h9876, 4'b0000, 4, 1'b0);
        apply_stimulus(4'b0001, SEG_TABLE[7], 4, 1'b0);
        apply_stimulus(4'b0010, SEG_TABLE[8], 4, 1'b0);
        apply_stimulus(4'b0100, 7'h00, 4, 1'b0);
        apply_stimulus(4'b1000, SEG_TABLE[5], 3, 1'b0);
        apply_stimulus(4'b1000, SEG_TABLE[5], 1, 1'b1);
        check_output("simul_valid", {31'h0, frame_valid}, 32'd1);
        check_output("simul_value", {16'h0, frame_value}, 32'h5087);
        check_output("simul_blank", {28'h0, frame_blank}, 32'h4);
        apply_stimulus(4'b0000, 7'h00, 2, 1'b1);

        // Reset with a partial frame staged
        apply_stimulus(4'b0001, SEG_TABLE[14], 4, 1'b0);
        apply_stimulus(4'b0010, SEG_TABLE[13], 4, 1'b0);
        reset_n = 1'b0;
        #1;
        check_output("midreset_value", {16'h0, frame_value}, 32'h0);
        check_output("midreset_valid", {31'h0, frame_valid}, 32'h0);
        check_output("midreset_err", {31'h0, err_pulse}, 32'h0);
        model_reset();
        digit_sel = '0;
        seg_in    = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        apply_stimulus(4'b0100, SEG_TABLE[2], 4, 1'b1);
        apply_stimulus(4'b1000, SEG_TABLE[6], 4, 1'b1);
        apply_stimulus(4'b0001, SEG_TABLE[1], 4, 1'b1);
        apply_stimulus(4'b0010, SEG_TABLE[15], 4, 1'b1);
        apply_stimulus(4'b0000, 7'h00, 2, 1'b1);

        // Randomized traffic with random backpressure
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                7:       rsel = 4'b0000;
                8, 9: begin
                    rsel = 4'($urandom_range(0, 15));
                    while ($countones(rsel) < 2) rsel = 4'($urandom_range(0, 15));
                end
                default: rsel = 4'(1) << $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 9))
                8:       rseg = 7'h00;
                9:       rseg = 7'($urandom_range(0, 127));
                default: rseg = SEG_TABLE[$urandom_range(0, 15)];
            endcase
            hold = $urandom_range(1, 6);
            for (int k = 0; k < hold; k++) apply_stimulus(rsel, rseg, 1, 1'($urandom_range(0, 1)));
        end

        apply_stimulus(4'b0000, 7'h00, 8, 1'b1);
        check_output("frames_pending", exp_frames.size(), 32'd0);
        check_output("err_pending", exp_err.size(), 32'd0);
        check_output("ovf_pending", exp_ovf.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
